// File: rtl/iob_fifo_ram_ctrl_pkg.sv
// Default configuration for the RAM-backed FIFO controller.
package iob_fifo_ram_ctrl_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_AEMPTY = 2;

  // Almost-full threshold defaults to two words below depth.
  function automatic int unsigned afull_default(input int unsigned addr_w);
    return (32'd1 << addr_w) - 32'd2;
  endfunction

endpackage

// File: rtl/iob_fifo_ptr.sv
// Wrapping FIFO pointer: sync reset, increment enable; MSB flips on each wrap.
module iob_fifo_ptr #(
  parameter int unsigned W = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/iob_fifo_ram_ctrl.sv
// Single-clock FIFO controller using an external two-port RAM with 1-cycle registered read.
module iob_fifo_ram_ctrl
  import iob_fifo_ram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned AFULL  = afull_default(ADDR_W),
  parameter int unsigned AEMPTY = DEF_AEMPTY
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              w_en_i,
  input  logic [DATA_W-1:0] w_data_i,
  output logic              w_full_o,
  output logic              w_afull_o,
  output logic              w_ovf_o,
  input  logic              r_en_i,
  output logic [DATA_W-1:0] r_data_o,
  output logic              r_valid_o,
  output logic              r_empty_o,
  output logic              r_aempty_o,
  output logic              r_unf_o,
  output logic [ADDR_W:0]   level_o,
  output logic              ext_mem_w_en_o,
  output logic [ADDR_W-1:0] ext_mem_w_addr_o,
  output logic [DATA_W-1:0] ext_mem_w_data_o,
  output logic              ext_mem_r_en_o,
  output logic [ADDR_W-1:0] ext_mem_r_addr_o,
  input  logic [DATA_W-1:0] ext_mem_r_data_i
);

  localparam int unsigned     LVL_W = ADDR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH = LVL_W'(2 ** ADDR_W);

  logic [LVL_W-1:0] wptr;
  logic [LVL_W-1:0] rptr;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_nxt_c;
  logic             push_acc_c;
  logic             pop_acc_c;
  logic             full_q;
  logic             afull_q;
  logic             empty_q;
  logic             aempty_q;
  logic             ovf_q;
  logic             unf_q;
  logic             valid_q;

  // Guards keep the RAM from ever seeing a read and a write to the same word.
  always_comb begin
    push_acc_c  = w_en_i & ~full_q;
    pop_acc_c   = r_en_i & ~empty_q;
    level_nxt_c = (wptr + LVL_W'(push_acc_c)) - (rptr + LVL_W'(pop_acc_c));
  end

  iob_fifo_ptr #(.W(LVL_W)) u_wptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (push_acc_c),
    .ptr   (wptr)
  );

  iob_fifo_ptr #(.W(LVL_W)) u_rptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (pop_acc_c),
    .ptr   (rptr)
  );

  // Level and flags are registered together from the next-state level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= (AFULL == 0);
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      level_q  <= level_nxt_c;
      full_q   <= (level_nxt_c == DEPTH);
      afull_q  <= (level_nxt_c >= LVL_W'(AFULL));
      empty_q  <= (level_nxt_c == '0);
      aempty_q <= (level_nxt_c <= LVL_W'(AEMPTY));
      ovf_q    <= ovf_q | (w_en_i & full_q);
      unf_q    <= unf_q | (r_en_i & empty_q);
      valid_q  <= pop_acc_c;
    end
  end

  assign w_full_o         = full_q;
  assign w_afull_o        = afull_q;
  assign w_ovf_o          = ovf_q;
  assign r_empty_o        = empty_q;
  assign r_aempty_o       = aempty_q;
  assign r_unf_o          = unf_q;
  assign r_valid_o        = valid_q;
  assign level_o          = level_q;
  assign r_data_o         = ext_mem_r_data_i;

  assign ext_mem_w_en_o   = push_acc_c;
  assign ext_mem_w_addr_o = wptr[ADDR_W-1:0];
  assign ext_mem_w_data_o = w_data_i;
  assign ext_mem_r_en_o   = pop_acc_c;
  assign ext_mem_r_addr_o = rptr[ADDR_W-1:0];

endmodule
